// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
//   uart_state_e  - transmitter state encodings
//   PAR_*         - parity mode constants for the PARITY parameter
//   parity_bit()  - parity of a (zero-extended) data word for a given mode
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned MAX_DATA_W = 9;

    // Zero-extension of the word does not change its XOR, so one width serves all.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] d,
                                        input int unsigned         mode);
        logic x;
        x = ^d;
        case (mode)
            PAR_ODD:  parity_bit = ~x;
            PAR_EVEN: parity_bit = x;
            default:  parity_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, counts 0..DIV-1 and wraps.
//   clk, rst_n - clock, async active-low reset
//   clr        - hold the count at 0
//   tick       - high while the count equals DIV-1 (last cycle of a bit)
module uart_baud_cnt #(
    parameter int unsigned DIV = 2500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: clear, wrap at the end of a bit, otherwise increment.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (start, data LSB first, optional
// parity, 1 or 2 stop bits).
//   clk, rst_n - clock, async active-low reset
//   data_in    - word to send, captured when in_valid && in_ready
//   in_valid   - data_in valid
//   in_ready   - registered, high only in IDLE
//   tx         - registered serial line, idle high
//   busy       - registered, high while a frame is in progress
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned BD_DIVIDER = 2500,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);

    // Parameter legality checks
    if (BD_DIVIDER < 2 || BD_DIVIDER > 65535) begin : g_bad_div
        $error("uart_tx_cfg: BD_DIVIDER out of range 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS out of range 5..9");
    end
    if (PARITY > 2) begin : g_bad_par
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 par_q, par_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, tx_d;
    logic                 rdy_q, rdy_d;
    logic                 busy_q, busy_d;
    logic                 tick;
    logic                 clr;

    // Counter is held at 0 while idle so a new frame starts a full bit period.
    assign clr = (state_q == IDLE);

    uart_baud_cnt #(
        .DIV (BD_DIVIDER)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    // Next-state, datapath and output values; tx_d is the level for the next bit.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        par_d   = par_q;
        stop_d  = stop_q;
        tx_d    = tx_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (in_valid && rdy_q) begin
                    sh_d    = data_in;
                    par_d   = parity_bit(MAX_DATA_W'(data_in), PARITY);
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = sh_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        stop_d = 1'b0;
                        if (PARITY != PAR_NONE) begin
                            tx_d    = par_q;
                            state_d = PAR;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_q == LAST_STOP) begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign in_ready = rdy_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four transmitter configurations (8N1, 8O1, 8E1, 7E2) at
// BD_DIVIDER=4, checked cycle by cycle against a bit-list frame model.
module tb_uart_tx_cfg;

    localparam int unsigned BD = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] din [4];
    logic       vld [4];
    logic       rdy [4];
    logic       txs [4];
    logic       bsy [4];

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    int db [4] = '{8, 8, 8, 7};
    int pm [4] = '{0, 1, 2, 2};
    int sb [4] = '{1, 1, 1, 2};

    bit exp_q [$];

    always #5 clk = ~clk;

    uart_tx_cfg #(.BD_DIVIDER(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n81 (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]));
    uart_tx_cfg #(.BD_DIVIDER(BD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o81 (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]));
    uart_tx_cfg #(.BD_DIVIDER(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e81 (
        .clk(clk), .rst_n(rst_n), .data_in(din[2]), .in_valid(vld[2]),
        .in_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]));
    uart_tx_cfg #(.BD_DIVIDER(BD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_e72 (
        .clk(clk), .rst_n(rst_n), .data_in(din[3][6:0]), .in_valid(vld[3]),
        .in_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference frame as a list of line levels, one entry per bit.
    task automatic build_frame(input int k, input logic [7:0] d);
        int ones;
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < db[k]; i++) begin
            exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (pm[k] == 1) exp_q.push_back((ones % 2) == 0);
        if (pm[k] == 2) exp_q.push_back((ones % 2) == 1);
        for (int i = 0; i < sb[k]; i++) exp_q.push_back(1'b1);
    endtask

    // Send one word on DUT k and check every cycle of the frame plus the idle cycle after it.
    // preloaded: in_valid/data_in already driven from the previous frame (back-to-back).
    // keep_valid: leave in_valid high with nxt on data_in after acceptance.
    task automatic send(input int k, input logic [7:0] d, input bit noise,
                        input bit keep_valid, input logic [7:0] nxt, input bit preloaded);
        int len;
        if (!preloaded) begin
            for (int i = 0; i < 200 && !rdy[k]; i++) @(negedge clk);
            if (!rdy[k]) begin
                check_eq($sformatf("u%0d_ready_wait", k), 32'(rdy[k]), 32'd1);
                return;
            end
            vld[k] = 1'b1;
            din[k] = d;
        end
        @(posedge clk);
        #1;
        if (keep_valid) din[k] = nxt;
        else            vld[k] = 1'b0;
        build_frame(k, d);
        len = exp_q.size() * BD;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            check_eq($sformatf("u%0d_tx_c%0d", k, c), 32'(txs[k]), 32'(exp_q[c / BD]));
            check_eq($sformatf("u%0d_busy_c%0d", k, c), 32'(bsy[k]), 32'd1);
            check_eq($sformatf("u%0d_rdy_c%0d", k, c), 32'(rdy[k]), 32'd0);
            if (noise && !keep_valid) begin
                vld[k] = (c < len - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                din[k] = 8'($urandom);
            end
        end
        @(negedge clk);
        check_eq($sformatf("u%0d_idle_tx", k), 32'(txs[k]), 32'd1);
        check_eq($sformatf("u%0d_idle_busy", k), 32'(bsy[k]), 32'd0);
        check_eq($sformatf("u%0d_idle_rdy", k), 32'(rdy[k]), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0;
            din[k] = 8'h00;
        end
        #12;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("u%0d_rst_tx", k), 32'(txs[k]), 32'd1);
            check_eq($sformatf("u%0d_rst_rdy", k), 32'(rdy[k]), 32'd0);
            check_eq($sformatf("u%0d_rst_busy", k), 32'(bsy[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("u%0d_rdy_after_rst", k), 32'(rdy[k]), 32'd1);
            check_eq($sformatf("u%0d_tx_after_rst", k), 32'(txs[k]), 32'd1);
        end

        // Directed frames
        send(0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
        send(2, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
        send(1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
        send(1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        send(3, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0);

        // Back-to-back with in_valid held high
        send(0, 8'h55, 1'b0, 1'b1, 8'hAA, 1'b0);
        send(0, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b1);

        // Input activity during a frame, then no extra frame afterwards
        send(0, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("noise_no_extra_tx", 32'(txs[0]), 32'd1);
            check_eq("noise_no_extra_busy", 32'(bsy[0]), 32'd0);
        end

        // Randomized frames across configurations
        for (int n = 0; n < 16; n++) begin
            int k;
            k = int'($urandom_range(0, 3));
            send(k, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
        end

        // Reset asserted during data bit 3
        vld[0] = 1'b1;
        din[0] = 8'h3C;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        repeat (17) @(negedge clk);
        check_eq("pre_rst_busy", 32'(bsy[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("u%0d_mid_rst_tx", k), 32'(txs[k]), 32'd1);
            check_eq($sformatf("u%0d_mid_rst_rdy", k), 32'(rdy[k]), 32'd0);
            check_eq($sformatf("u%0d_mid_rst_busy", k), 32'(bsy[k]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("post_rst_tx", 32'(txs[0]), 32'd1);
            check_eq("post_rst_busy", 32'(bsy[0]), 32'd0);
            check_eq("post_rst_rdy", 32'(rdy[0]), 32'd1);
        end

        // A fresh frame works after the aborted one
        send(0, 8'h96, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
